// File: rtl/ps2_pkg.sv
// Shared types, default timing constants and parity helper for the PS/2 host command path.
package ps2_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_ACK,
      S_DONE,
      S_NOACK,
      S_TOUT
   } ps2_cmd_state_e;

   // Defaults assume a 50 MHz clk.
   localparam int DEF_INHIBIT_CYCLES       = 5000;
   localparam int DEF_START_TIMEOUT_CYCLES = 750000;
   localparam int DEF_XFER_TIMEOUT_CYCLES  = 100000;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_cmd_timer.sv
// Loadable down-counter that sticks at zero; expired is high while the count is zero.
module ps2_cmd_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign expired = (count == '0);

endmodule

// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, data/parity/stop, ack.
// Define PS2_CMD_TIMEOUT_EN to build the start and transfer timeouts (TOUT path).
module ps2_command_out
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
   parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
   parameter int XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] the_command,
   input  logic       send_command,
   input  logic       ps2_clk_posedge,
   input  logic       ps2_clk_negedge,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       command_was_sent,
   output logic       error_no_ack,
   output logic       error_timed_out
);

   localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_MAX = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                           START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
   localparam int TO_W   = $clog2(TO_MAX + 1);

   ps2_cmd_state_e  state, nxt;
   logic [7:0]      shift, nxt_shift;
   logic [2:0]      idx, nxt_idx;
   logic            parity, nxt_parity;
   logic            inh_load, inh_exp;
   logic            to_load, to_exp;
   logic [TO_W-1:0] to_load_val;
   logic            data_oe_nxt, busy_nxt;

   // Loaded one short so the clock is held low for exactly INHIBIT_CYCLES cycles.
   ps2_cmd_timer #(.W(INH_W)) u_inhibit (
      .clk        (clk),
      .reset      (reset),
      .load       (inh_load),
      .load_value (INH_W'(INHIBIT_CYCLES - 1)),
      .expired    (inh_exp)
   );

`ifdef PS2_CMD_TIMEOUT_EN
   ps2_cmd_timer #(.W(TO_W)) u_timeout (
      .clk        (clk),
      .reset      (reset),
      .load       (to_load),
      .load_value (to_load_val),
      .expired    (to_exp)
   );
`else
   logic unused_to;
   assign unused_to = ^{to_load, to_load_val};
   assign to_exp    = 1'b0;
`endif

   always_comb begin
      nxt         = state;
      nxt_shift   = shift;
      nxt_idx     = idx;
      nxt_parity  = parity;
      inh_load    = 1'b0;
      to_load     = 1'b0;
      to_load_val = '0;
      case (state)
         S_IDLE:
            if (send_command) begin
               nxt        = S_INHIBIT;
               nxt_shift  = the_command;
               nxt_parity = odd_parity(the_command);
               inh_load   = 1'b1;
            end
         S_INHIBIT:
            if (inh_exp) begin
               nxt         = S_RTS;
               to_load     = 1'b1;
               to_load_val = TO_W'(START_TIMEOUT_CYCLES - 1);
            end
         S_RTS:
            if (ps2_clk_negedge) begin
               nxt         = S_DATA;
               nxt_idx     = '0;
               to_load     = 1'b1;
               to_load_val = TO_W'(XFER_TIMEOUT_CYCLES - 1);
            end else if (to_exp) nxt = S_TOUT;
         S_DATA:
            if (ps2_clk_negedge) begin
               if (idx == 3'd7) nxt = S_PARITY;
               else begin
                  nxt_shift = shift >> 1;
                  nxt_idx   = idx + 3'd1;
               end
            end else if (to_exp) nxt = S_TOUT;
         S_PARITY:
            if (ps2_clk_negedge) nxt = S_STOP;
            else if (to_exp)     nxt = S_TOUT;
         S_STOP:
            if (ps2_clk_posedge) nxt = S_ACK;
            else if (to_exp)     nxt = S_TOUT;
         S_ACK:
            if (ps2_clk_posedge) nxt = ps2_data ? S_NOACK : S_DONE;
            else if (to_exp)     nxt = S_TOUT;
         default: nxt = S_IDLE;
      endcase

      // Outputs are registered from the next state so they track it with no extra lag.
      case (nxt)
         S_RTS:    data_oe_nxt = 1'b1;
         S_DATA:   data_oe_nxt = ~nxt_shift[0];
         S_PARITY: data_oe_nxt = ~nxt_parity;
         default:  data_oe_nxt = 1'b0;
      endcase
      busy_nxt = nxt inside {S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_ACK};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         shift            <= '0;
         idx              <= '0;
         parity           <= 1'b0;
         ps2_clk_oe       <= 1'b0;
         ps2_data_oe      <= 1'b0;
         busy             <= 1'b0;
         command_was_sent <= 1'b0;
         error_no_ack     <= 1'b0;
      end else begin
         state            <= nxt;
         shift            <= nxt_shift;
         idx              <= nxt_idx;
         parity           <= nxt_parity;
         ps2_clk_oe       <= (nxt == S_INHIBIT);
         ps2_data_oe      <= data_oe_nxt;
         busy             <= busy_nxt;
         command_was_sent <= (nxt == S_DONE);
         error_no_ack     <= (nxt == S_NOACK);
      end
   end

`ifdef PS2_CMD_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) error_timed_out <= 1'b0;
      else       error_timed_out <= (nxt == S_TOUT);
   end
`else
   assign error_timed_out = 1'b0;
`endif

endmodule
